main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 149 ++++++++++++++
 tb/tb_main_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// main_fsm -- multicycle processor control FSM.
//
// Walks each instruction through fetch, decode and the execute states for
// its class. It drives the datapath enables and mux selects, and raises
// instr_done when the instruction retires.
//
// Ports:
//   clk, reset_n        rising-edge clock, async active-low reset
//   op[1:0]             instr[27:26]: 00 DP, 01 memory, 10 branch, 11 undefined
//   funct[5:0]          instr[25:20]: [5] immediate operand, [0] load(1)/store(0)
//   mem_ready           memory access completes this cycle
//   ir_write, next_pc   instruction-register load and PC advance (fetch)
//   reg_w, mem_w        register file / memory write enables
//   branch, alu_op      branch taken, ALU performs the decoded op (else add)
//   adr_src             memory address from ALU result (else PC)
//   alu_src_a/b         ALU operand selects
//   result_src          result bus select
//   instr_done          one-cycle retire pulse
//   state[3:0]          current state, exposed for debug
module main_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       next_pc,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       alu_op,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  assign state = state_q;

  // Outputs are Moore on state. The exceptions are the fetch strobes and
  // the store retire pulse, which follow mem_ready combinationally, and the
  // undefined-op retire, which follows op in DECODE.
  always_comb begin
    state_d    = S_FETCH;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        next_pc    = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            // Undefined op retires as a no-op straight from decode.
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // mem_w stays high for the whole stall; retire when memory accepts.
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;  // unused encodings recover to fetch
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm. Each cycle compares the state and the
// packed output vector against hand-written constants for that state.
module tb_main_fsm;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src, instr_done;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] state;

  int n_run  = 0;
  int n_fail = 0;

  main_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .ir_write(ir_write), .next_pc(next_pc), .reg_w(reg_w), .mem_w(mem_w),
    .branch(branch), .alu_op(alu_op), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  // {ir_write,next_pc,reg_w,mem_w,branch,alu_op,adr_src,a[1:0],b[1:0],rs[1:0],done}
  logic [13:0] outs;
  assign outs = {ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
                 alu_src_a, alu_src_b, result_src, instr_done};

  localparam logic [13:0] O_FETCH1 = 14'b11_0000_0_01_10_10_0;
  localparam logic [13:0] O_FETCH0 = 14'b00_0000_0_01_10_10_0;
  localparam logic [13:0] O_DEC    = 14'b00_0000_0_01_10_10_0;
  localparam logic [13:0] O_DECUND = 14'b00_0000_0_01_10_10_1;
  localparam logic [13:0] O_MEMADR = 14'b00_0000_0_00_01_00_0;
  localparam logic [13:0] O_MEMRD  = 14'b00_0000_1_00_00_00_0;
  localparam logic [13:0] O_MEMWB  = 14'b00_1000_0_00_00_01_1;
  localparam logic [13:0] O_MEMWR0 = 14'b00_0100_1_00_00_00_0;
  localparam logic [13:0] O_MEMWR1 = 14'b00_0100_1_00_00_00_1;
  localparam logic [13:0] O_EXECR  = 14'b00_0001_0_00_00_00_0;
  localparam logic [13:0] O_EXECI  = 14'b00_0001_0_00_01_00_0;
  localparam logic [13:0] O_ALUWB  = 14'b00_1000_0_00_00_00_1;
  localparam logic [13:0] O_BRANCH = 14'b00_0010_0_10_01_10_1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply mem_ready for this cycle, check state and outputs, then advance.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] es,
                     input logic [13:0] eo);
    mem_ready = mr;
    #1;
    chk({tag, ".state"}, {12'd0, state}, {12'd0, es});
    chk({tag, ".outs"},  {2'd0, outs},   {2'd0, eo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; op = 2'b00; funct = 6'b001000;
    #1;
    chk("rst.state", {12'd0, state}, 16'd0);
    chk("rst.outs_mr1", {2'd0, outs}, {2'd0, O_FETCH1});
    mem_ready = 1'b0;
    #1;
    chk("rst.outs_mr0", {2'd0, outs}, {2'd0, O_FETCH0});
    mem_ready = 1'b1;
    #1 reset_n = 1'b1;          // released before the first edge at t=5
    @(posedge clk); #1;
    // First edge evaluates from FETCH: now in DECODE.
    chk("rel.state", {12'd0, state}, 16'd1);
    @(posedge clk); #1;         // DECODE -> EXECR
    @(posedge clk); #1;         // EXECR -> ALUWB
    @(posedge clk); #1;         // ALUWB -> FETCH

    // ADD register: 0,1,6,8,0
    op = 2'b00; funct = 6'b001000;
    cyc("add.f", 1'b1, 4'd0, O_FETCH1);
    cyc("add.d", 1'b1, 4'd1, O_DEC);
    cyc("add.x", 1'b1, 4'd6, O_EXECR);
    cyc("add.w", 1'b1, 4'd8, O_ALUWB);

    // ADD immediate: 0,1,7,8
    op = 2'b00; funct = 6'b101000;
    cyc("addi.f", 1'b1, 4'd0, O_FETCH1);
    cyc("addi.d", 1'b1, 4'd1, O_DEC);
    cyc("addi.x", 1'b1, 4'd7, O_EXECI);
    cyc("addi.w", 1'b1, 4'd8, O_ALUWB);

    // LDR with a fetch stall and a 3-cycle read stall; op scrambled mid-read.
    op = 2'b01; funct = 6'b011001;
    cyc("ldr.fs", 1'b0, 4'd0, O_FETCH0);
    cyc("ldr.f",  1'b1, 4'd0, O_FETCH1);
    cyc("ldr.d",  1'b1, 4'd1, O_DEC);
    cyc("ldr.a",  1'b1, 4'd2, O_MEMADR);
    op = 2'b11; funct = 6'b000000;
    cyc("ldr.r0", 1'b0, 4'd3, O_MEMRD);
    cyc("ldr.r1", 1'b0, 4'd3, O_MEMRD);
    cyc("ldr.r2", 1'b0, 4'd3, O_MEMRD);
    cyc("ldr.r3", 1'b1, 4'd3, O_MEMRD);
    cyc("ldr.wb", 1'b1, 4'd4, O_MEMWB);

    // STR with a 2-cycle write stall.
    op = 2'b01; funct = 6'b011000;
    cyc("str.f",  1'b1, 4'd0, O_FETCH1);
    cyc("str.d",  1'b1, 4'd1, O_DEC);
    cyc("str.a",  1'b1, 4'd2, O_MEMADR);
    cyc("str.w0", 1'b0, 4'd5, O_MEMWR0);
    cyc("str.w1", 1'b0, 4'd5, O_MEMWR0);
    cyc("str.w2", 1'b1, 4'd5, O_MEMWR1);

    // Branch: 0,1,9
    op = 2'b10; funct = 6'b000000;
    cyc("b.f", 1'b1, 4'd0, O_FETCH1);
    cyc("b.d", 1'b1, 4'd1, O_DEC);
    cyc("b.x", 1'b1, 4'd9, O_BRANCH);

    // Undefined op retires from DECODE.
    op = 2'b11;
    cyc("und.f", 1'b1, 4'd0, O_FETCH1);
    cyc("und.d", 1'b1, 4'd1, O_DECUND);
    cyc("und.e", 1'b1, 4'd0, O_FETCH1);   // back in FETCH, next fetch begins

    // Reset pulse in the middle of a MEMWRITE stall.
    op = 2'b01; funct = 6'b011000;
    cyc("rw.d", 1'b1, 4'd1, O_DEC);
    cyc("rw.a", 1'b1, 4'd2, O_MEMADR);
    mem_ready = 1'b0;
    #2;
    chk("rw.pre", {12'd0, state}, 16'd5);
    chk("rw.pre_memw", {15'd0, mem_w}, 16'd1);
    reset_n = 1'b0;
    #1;
    chk("rw.state", {12'd0, state}, 16'd0);
    chk("rw.memw",  {15'd0, mem_w}, 16'd0);
    chk("rw.outs",  {2'd0, outs}, {2'd0, O_FETCH0});
    #2 reset_n = 1'b1;
    op = 2'b10;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("rw.d2", 1'b1, 4'd1, O_DEC);
    cyc("rw.b",  1'b1, 4'd9, O_BRANCH);
    cyc("rw.f",  1'b1, 4'd0, O_FETCH1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
